// File: rtl/mips32_mem_responder.sv
// Data-memory responder for the MIPS32 MEM stage: valid/ready request and response channels,
// programmable wait states and out-of-range flagging. Define MEM_RESP_WRITE_ACK_EN to acknowledge stores.
module mips32_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Any address bit above the array index makes the access out of range.
  function automatic logic addr_out_of_range(input logic [31:0] addr);
    logic [31:0] hi_mask;
    hi_mask = ~((32'd1 << ADDR_W) - 32'd1);
    return |(addr & hi_mask);
  endfunction

  logic [31:0]       mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              req_ready_q;
  logic              busy_q;
  logic              mem_we_s;
  logic              oor_s;
  logic [ADDR_W-1:0] idx_s;

  assign idx_s = addr_q[ADDR_W-1:0];
  assign oor_s = addr_out_of_range(addr_q);

  // Next-state, capture and commit logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = WAIT_INIT;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (we_q) begin
          mem_we_s    = ~oor_s;
          rsp_rdata_d = 32'd0;
`ifdef MEM_RESP_WRITE_ACK_EN
          rsp_err_d   = oor_s;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
`else
          // Silent store: no beat, so there is nothing to flag.
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
`endif
        end else begin
          rsp_rdata_d = oor_s ? 32'd0 : mem_q[idx_s];
          rsp_err_d   = oor_s;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, request capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= wdata_q;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/mips32_mem_responder.md
# mips32_mem_responder

Single-port data-memory responder that serves LW/SW requests issued by the MIPS32 pipeline's MEM stage over a valid/ready request channel and a valid/ready response channel. Holds a 2^ADDR_W x 32 word-addressed array, inserts a programmable number of wait states, and flags out-of-range addresses. Sits between the core's MEM stage and the data memory, so that stage no longer indexes a memory array directly.

## Interface
- ADDR_W, default 10: word-address width; the array holds 2^ADDR_W words (1024 by default).
- WAIT_CYCLES, default 2: wait states per access, legal range 0..15.

- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store (SW), 0 = load (LW).
- req_addr  in  32  word address; this is the core's ALU output.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core can take the response.
- rsp_rdata  out  32  load data; 0 for writes and for errors.
- rsp_err  out  1  address out of range.
- busy  out  1  high in every state except IDLE.

## Operation
- The block has three states: IDLE, WAIT and RESP. Only one request is outstanding at a time.
- IDLE:
  - req_ready = 1.
  - When req_valid is high at a clock edge, the block captures we, addr and wdata.
  - It loads cnt = WAIT_CYCLES and moves to WAIT.
- WAIT:
  - req_ready = 0.
  - When cnt != 0, the block decrements cnt.
  - When cnt == 0, the block commits the access:
    - Load: it registers Mem[addr[ADDR_W-1:0]] into rsp_rdata.
    - Store: it writes wdata to Mem[addr[ADDR_W-1:0]] and sets rsp_rdata = 0.
  - After the commit it moves to RESP, or to IDLE for a store when MEM_RESP_WRITE_ACK_EN is not defined.
- Range check:
  - A request is out of range when req_addr[31:ADDR_W] != 0.
  - Out-of-range stores are suppressed, so memory is unchanged.
  - Out-of-range loads return rsp_rdata = 0.
  - rsp_err = 1 in both cases.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - When rsp_ready is high at a clock edge, the block clears rsp_valid and moves to IDLE.
- Reset values:
  - state = IDLE, cnt = 0.
  - req_ready = 1 (from IDLE), rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - Array contents are not reset.
- Reset mid-operation: the block returns to IDLE immediately. A store still in WAIT is never committed, and a pending response is dropped.

## Timing
- Request accepted at edge N.
- The commit and the rise of rsp_valid happen at edge N+WAIT_CYCLES+1 (for example N+3 at the default, N+1 with WAIT_CYCLES = 0).
- rsp_valid stays high until the first edge where rsp_ready = 1, which may be the same edge rsp_valid becomes visible plus one. That edge returns the block to IDLE.
- req_ready returns high in the cycle after that handshake edge. There is no same-edge accept, so the minimum spacing between accepts is WAIT_CYCLES+3 edges.
- Without write acknowledgement, a store returns to IDLE at its commit edge, giving WAIT_CYCLES+2 edges between accepts.
- req_valid, req_we, req_addr and req_wdata are ignored outside IDLE.
- req_valid may drop before acceptance without side effects.
- rsp_rdata changes only at the commit edge and at reset.

## Configuration
- Macro: MEM_RESP_WRITE_ACK_EN.
- Defined: every store produces a RESP beat with rsp_rdata = 0 and rsp_err set per the range check. The core must consume this beat.
- Undefined: stores complete silently at the commit edge with rsp_valid held at 0, and out-of-range stores are dropped without signalling. Loads behave identically in both builds.

## Test plan
- Reset mid-operation: assert rst_n = 0 while a store of 0x12345678 to address 9 is in WAIT, then read address 9 -> the data is unchanged, and all outputs took their reset values asynchronously.
- Store then load, WAIT_CYCLES = 2: store 0xDEADBEEF to address 0x3FF, then load 0x3FF -> rsp_rdata = 0xDEADBEEF with rsp_err = 0, and the load's rsp_valid rises 3 edges after its accept.
- Out-of-range load from 0x400 -> rsp_err = 1 and rsp_rdata = 0. An out-of-range store of 0x5A5A5A5A to 0x400 followed by a load from 0x000 -> address 0 is unchanged.
- Backpressure: hold rsp_ready = 0 for 5 cycles on a load -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; release rsp_ready -> IDLE one edge later.
- WAIT_CYCLES = 0: load address 5 holding 0x00000007 -> rsp_valid visible at edge N+1 with 0x00000007.
- Store response: with MEM_RESP_WRITE_ACK_EN defined, a store to address 1 yields one rsp_valid beat with rsp_rdata = 0. With it undefined, rsp_valid stays 0 throughout and req_ready returns high after WAIT_CYCLES+2 edges.
